ddr2pe_b: RTL

//  Inbound counterpart of the PE-to-DDR drain path: accepts a DDR read stream
//  (valid/ready) and unpacks each DDR_W word into DATA_W or TAIL_W sub-words,

---
 rtl/ddr2pe_b.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ddr2pe_b.sv
// ddr2pe_b: DDR read stream -> PE bias buffer unpacker.
// Each accepted DDR word is split into DATA_W or TAIL_W sub-words, LSBs first.
// Each sub-word becomes one bbuf write, at consecutive addresses from 0.
module ddr2pe_b #(
  parameter int BUF_DEPTH = 256,
  parameter int ADDR_W    = $clog2(BUF_DEPTH),
  parameter int DDR_W     = 64,
  parameter int DATA_W    = 16,
  parameter int TAIL_W    = 8,
  localparam int RES_W    = DATA_W + TAIL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  input  logic              conf_trans_type,
  input  logic [7:0]        conf_trans_num,
  input  logic [DDR_W-1:0]  ddr1_data,
  input  logic              ddr1_valid,
  output logic              ddr1_ready,
  output logic [ADDR_W-1:0] bbuf_wr_addr,
  output logic [RES_W-1:0]  bbuf_wr_data,
  output logic [1:0]        bbuf_wr_mask,
  output logic              bbuf_wr_en
);

  localparam int DATA_PACK = DDR_W / DATA_W;
  localparam int TAIL_PACK = DDR_W / TAIL_W;
  localparam int SUB_W     = $clog2(TAIL_PACK);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic              type_q;
  logic [7:0]        num_q;
  logic [DDR_W-1:0]  hold_data;
  logic              hold_valid;
  logic [SUB_W-1:0]  sub_cnt;
  logic [8:0]        wr_cnt;
  logic [8:0]        word_cnt;

  logic [8:0]        need_words;
  logic              all_accepted;
  logic              last_sub;
  logic              final_entry;
  logic              take;
  logic              emit;
  logic [DDR_W-1:0]  sel_word;
  logic [SUB_W-1:0]  sel_idx;
  logic [DDR_W-1:0]  shifted_data;
  logic [DDR_W-1:0]  shifted_tail;
  logic [DATA_W-1:0] sub_data;
  logic [TAIL_W-1:0] sub_tail;

  // State register; reset and restart both handled synchronously.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: start always (re)enters RUN; RUN ends once every entry is written.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (start)                        state_next = RUN;
        else if (wr_cnt == {1'b0, num_q}) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake control and sub-word selection.
  // A word's first sub-word is written straight from the DDR bus. The word is
  // then held only while sub-words are still pending. A new word is therefore
  // taken in the cycle right after the last pending sub-word was issued.
  // This keeps one write per cycle with no bubble between words.
  always_comb begin
    need_words = type_q ? 9'((32'(num_q) + TAIL_PACK - 1) / TAIL_PACK)
                        : 9'((32'(num_q) + DATA_PACK - 1) / DATA_PACK);
    all_accepted = (word_cnt >= need_words);
    last_sub = type_q ? (sub_cnt == SUB_W'(TAIL_PACK - 1))
                      : (sub_cnt == SUB_W'(DATA_PACK - 1));
    final_entry = ((wr_cnt + 9'd1) == {1'b0, num_q});
    ddr1_ready = (state == RUN) && !all_accepted && !hold_valid;
    take = ddr1_ready && ddr1_valid;
    emit = (state == RUN) && (hold_valid || take);
    sel_word = hold_valid ? hold_data : ddr1_data;
    sel_idx = hold_valid ? sub_cnt : '0;
    shifted_data = sel_word >> (32'(sel_idx) * DATA_W);
    shifted_tail = sel_word >> (32'(sel_idx) * TAIL_W);
    sub_data = shifted_data[DATA_W-1:0];
    sub_tail = shifted_tail[TAIL_W-1:0];
  end

  // Run bookkeeping, hold register and registered bbuf write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      type_q       <= 1'b0;
      num_q        <= '0;
      hold_data    <= '0;
      hold_valid   <= 1'b0;
      sub_cnt      <= '0;
      wr_cnt       <= '0;
      word_cnt     <= '0;
      done         <= 1'b1;
      bbuf_wr_en   <= 1'b0;
      bbuf_wr_addr <= '0;
      bbuf_wr_data <= '0;
      bbuf_wr_mask <= 2'b00;
    end else begin
      bbuf_wr_en <= 1'b0;
      if (start) begin
        type_q     <= conf_trans_type;
        num_q      <= conf_trans_num;
        hold_valid <= 1'b0;
        sub_cnt    <= '0;
        wr_cnt     <= '0;
        word_cnt   <= '0;
        done       <= 1'b0;
      end else if (state == RUN) begin
        if (wr_cnt == {1'b0, num_q}) done <= 1'b1;
        if (take) begin
          hold_data <= ddr1_data;
          word_cnt  <= word_cnt + 9'd1;
        end
        if (emit) begin
          bbuf_wr_en   <= 1'b1;
          bbuf_wr_addr <= wr_cnt[ADDR_W-1:0];
          bbuf_wr_mask <= type_q ? 2'b01 : 2'b10;
          bbuf_wr_data <= type_q ? {{DATA_W{1'b0}}, sub_tail}
                                 : {sub_data, {TAIL_W{1'b0}}};
          wr_cnt       <= wr_cnt + 9'd1;
          if (hold_valid) begin
            sub_cnt <= sub_cnt + SUB_W'(1);
            if (last_sub || final_entry) hold_valid <= 1'b0;
          end else begin
            sub_cnt    <= SUB_W'(1);
            hold_valid <= !final_entry;
          end
        end
      end
    end
  end

endmodule
